dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Shared data-memory responder for the multi-core build.
- Each core acts as initiator. It drives address, write data and a write flag, and asserts a request.
- This block arbitrates round-robin, performs the single-port RAM access, and returns a one-cycle ack per core with read data.
- Sits between the NCORES core instances and the single external data RAM. Replaces the direct core-to-RAM hookup.

Parameters:
- NCORES, 4, number of requesting cores (2..8)
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, RAM read latency in clocks after the address-sampling edge (1..3)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- core_req  input  NCORES  request per core; held high until that core's ack
- core_we  input  NCORES  1 = write, 0 = read; valid while req high
- core_addr  input  NCORES*AW  core i address at [i*AW +: AW]
- core_wdata  input  NCORES*DW  core i write data at [i*DW +: DW]
- core_ack  output  NCORES  one-hot, one-cycle completion pulse
- core_rdata  output  DW  read data, shared by all cores; valid in the ack cycle
- busy  output  1  high in any state other than IDLE
- mem_addr  output  AW  registered RAM address
- mem_wdata  output  DW  registered RAM write data
- mem_wren  output  1  RAM write enable, high only in ISSUE for writes
- mem_q  input  DW  RAM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; core_ack=0; core_rdata=0; mem_addr=0; mem_wdata=0; mem_wren=0; busy=0.
  - last_grant=NCORES-1, so core 0 wins the first arbitration.
  - Reset mid-transaction aborts it: no ack is issued and mem_wren drops immediately.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any core_req is high, grant = first requesting index searching last_grant+1, +2, ... modulo NCORES.
  - Latch grant, we, addr and wdata of the granted core; load mem_addr and mem_wdata; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_wren = latched we.
  - Write: go to ACK.
  - Read: load wait counter with RD_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, register mem_q into core_rdata; go to ACK.
- ACK (1 cycle):
  - core_ack[grant]=1; last_grant=grant; go to IDLE.
- Latency, with cycle 0 = IDLE cycle that samples the request:
  - Write: mem_wren high in cycle 1; ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - Next arbitration occurs in the cycle after ACK.
- core_rdata:
  - Holds its value after ACK until the next read capture.
  - Writes do not modify it.
- mem_addr and mem_wdata hold their last values in all states; only mem_wren qualifies a write.
- Handshake rules:
  - A core must drop core_req in the cycle after its ack. A request still high in the IDLE cycle after ACK is treated as a new request. Round-robin then prefers other requesters, so no core starves.
  - A core that drops core_req mid-transaction does not cancel it: the access completes on the latched values and the ack is still pulsed.
  - Changes to a core's addr/wdata/we after its grant are ignored.
- Requests arriving while busy wait; there is no queue beyond the per-core request line.
- Simultaneous requests in IDLE are resolved purely by round-robin order from last_grant.
- Exactly one access is in flight at any time. core_ack is never multi-hot.

Test Plan:
- Single write: core 0 writes addr 0x0005, data 0x1234, from IDLE at cycle 0 -> mem_wren=1 with mem_addr=0x0005 and mem_wdata=0x1234 in cycle 1; core_ack=0001 in cycle 2; busy low in cycle 3.
- Read back with RD_LAT=1 (RAM model returns 0x1234 for addr 5): core 1 reads 0x0005 -> core_ack=0010 in cycle 3 with core_rdata=0x1234; mem_wren stays 0 throughout. Repeat with RD_LAT=3 -> ack in cycle 5.
- Contention: all four cores request in the same cycle after reset -> acks in order core 0, 1, 2, 3; no ack cycle overlaps another.
- Fairness: after core 2 is served, cores 1 and 3 request together -> core 3 is served first, then core 1. Core 0 holding req continuously is never served twice before core 1 when core 1 is also requesting.
- Abort: assert rst low during WAIT of a read -> core_ack stays 0, state=IDLE, mem_wren=0. After release, the pending core_req is re-arbitrated with core 0 priority.
- Request withdrawal: core 2 issues a write, then drops req in ISSUE -> the RAM write still occurs and core_ack[2] pulses in cycle 2; later changes to its addr/wdata do not alter mem_addr/mem_wdata.

Source files
------------

// File: rtl/dmem_responder.sv
// Shared data-memory responder: round-robin arbitration of NCORES initiators
// onto one single-port RAM, with a one-cycle per-core completion pulse.
module dmem_responder #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES-1:0]      core_req,
  input  logic [NCORES-1:0]      core_we,
  input  logic [NCORES*AW-1:0]   core_addr,
  input  logic [NCORES*DW-1:0]   core_wdata,
  output logic [NCORES-1:0]      core_ack,
  output logic [DW-1:0]          core_rdata,
  output logic                   busy,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic                   mem_wren,
  input  logic [DW-1:0]          mem_q
);

  localparam int unsigned GW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned CW = 2;
  localparam logic [GW-1:0] LAST_RST = GW'(NCORES - 1);
  localparam logic [CW-1:0] RD_LAT_C = CW'(RD_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  state_e              state_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_grant_q;
  logic                we_q;
  logic [CW-1:0]       cnt_q;
  logic [NCORES-1:0]   core_ack_q;
  logic [DW-1:0]       core_rdata_q;
  logic                busy_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DW-1:0]       mem_wdata_q;
  logic                mem_wren_q;

  logic                arb_valid_c;
  logic [GW-1:0]       arb_idx_c;
  logic [AW-1:0]       sel_addr_c;
  logic [DW-1:0]       sel_wdata_c;
  logic                sel_we_c;
  logic [NCORES-1:0]   grant_oh_c;

  // Core index 'off' positions after 'base', wrapping modulo NCORES.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base,
                                           input int unsigned   off);
    return GW'((32'(base) + off) % NCORES);
  endfunction

  // Round-robin search: nearest requester after last_grant wins, so the
  // loop scans from the farthest slot inward and lets nearer hits override.
  always_comb begin
    arb_valid_c = 1'b0;
    arb_idx_c   = '0;
    for (int k = NCORES; k >= 1; k--) begin
      if (core_req[rr_idx(last_grant_q, k)]) begin
        arb_valid_c = 1'b1;
        arb_idx_c   = rr_idx(last_grant_q, k);
      end
    end
  end

  // Select the winning core's request fields.
  always_comb begin
    sel_addr_c  = core_addr[32'(arb_idx_c) * AW +: AW];
    sel_wdata_c = core_wdata[32'(arb_idx_c) * DW +: DW];
    sel_we_c    = core_we[arb_idx_c];
  end

  assign grant_oh_c = NCORES'(1) << grant_q;

  // Transaction FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      core_ack_q   <= '0;
      core_rdata_q <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid_c) begin
            grant_q     <= arb_idx_c;
            we_q        <= sel_we_c;
            mem_addr_q  <= sel_addr_c;
            mem_wdata_q <= sel_wdata_c;
            mem_wren_q  <= sel_we_c;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_wren_q <= 1'b0;
          if (we_q) begin
            core_ack_q <= grant_oh_c;
            state_q    <= ST_ACK;
          end else begin
            cnt_q   <= RD_LAT_C;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          // Last wait cycle: RAM output is valid now.
          if (cnt_q == CW'(1)) begin
            core_rdata_q <= mem_q;
            core_ack_q   <= grant_oh_c;
            state_q      <= ST_ACK;
          end
        end
        ST_ACK: begin
          core_ack_q   <= '0;
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level reference model on a
// RD_LAT=1 instance plus directed latency checks on a RD_LAT=3 instance.
module tb_dmem_responder;

  localparam int unsigned NC  = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned RDL = 1;

  logic clk;
  logic rst;

  // RD_LAT=1 instance
  logic [NC-1:0]    core_req, core_we, core_ack;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [DW-1:0]    core_rdata, mem_wdata, mem_q;
  logic [AW-1:0]    mem_addr;
  logic             busy, mem_wren;

  // RD_LAT=3 instance
  logic [NC-1:0]    req3, we3, ack3;
  logic [NC*AW-1:0] addr3;
  logic [NC*DW-1:0] wd3;
  logic [DW-1:0]    rdata3, mwd3, mq3;
  logic [AW-1:0]    maddr3;
  logic             busy3, mwren3;

  dmem_responder #(.NCORES(NC), .AW(AW), .DW(DW), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
    .core_rdata(core_rdata), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q));

  dmem_responder #(.NCORES(NC), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .core_req(req3), .core_we(we3),
    .core_addr(addr3), .core_wdata(wd3), .core_ack(ack3),
    .core_rdata(rdata3), .busy(busy3), .mem_addr(maddr3),
    .mem_wdata(mwd3), .mem_wren(mwren3), .mem_q(mq3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] ram_init(input int i);
    return DW'(32'hA000 + 32'(i) * 32'h0101);
  endfunction

  function automatic logic [DW-1:0] f3(input logic [AW-1:0] a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  // External RAM for the RD_LAT=1 instance: one registered read stage.
  logic [DW-1:0] ram [16];
  logic          ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 16; i++) ram[i] <= ram_init(i);
    end else if (mem_wren) begin
      ram[mem_addr[3:0]] <= mem_wdata;
    end
    mem_q <= ram[mem_addr[3:0]];
  end

  // Read-only RAM for the RD_LAT=3 instance: three read stages.
  logic [DW-1:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= f3(maddr3);
    p2 <= p1;
    p3 <= p2;
  end
  assign mq3 = p3;

  // Counters and reference-model state
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_q[$];
  int last_ack_cyc = 0;
  bit rnd_en = 1'b0;
  bit [NC-1:0] hold_mask = '0;
  bit [NC-1:0] ack_seen = '0;

  // One access in flight: granted in cycle t_s, acked in cycle t_e.
  bit            t_act = 1'b0;
  int            t_s, t_e, t_g;
  int            m_last = NC - 1;
  bit            t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare the RD_LAT=1 instance against the model for the current cycle,
  // then let the model arbitrate if no access is in flight.
  task automatic model_check();
    logic [NC-1:0] e_ack;
    bit e_busy, e_wren, ended;
    e_ack = '0; e_busy = 1'b0; e_wren = 1'b0; ended = 1'b0;
    if (!rst) begin
      t_act = 1'b0; m_last = NC - 1; m_rdata = '0; e_addr = '0; e_wdata = '0;
    end else if (t_act) begin
      e_busy = 1'b1;
      if (t_we && cyc == t_s + 1) begin
        e_wren = 1'b1;
        ref_mem[t_addr[3:0]] = t_wd;
      end
      if (cyc == t_e) begin
        e_ack[t_g] = 1'b1;
        ended = 1'b1;
        if (!t_we) m_rdata = ref_mem[t_addr[3:0]];
      end
    end
    chk("ack",   32'(core_ack),   32'(e_ack));
    chk("busy",  32'(busy),       32'(e_busy));
    chk("wren",  32'(mem_wren),   32'(e_wren));
    chk("rdata", 32'(core_rdata), 32'(m_rdata));
    chk("addr",  32'(mem_addr),   32'(e_addr));
    chk("wdata", 32'(mem_wdata),  32'(e_wdata));
    for (int i = 0; i < NC; i++) begin
      if (core_ack[i]) begin
        ack_q.push_back(i);
        last_ack_cyc = cyc;
      end
    end
    if (ended) begin
      ack_seen[t_g] = 1'b1;
      m_last = t_g;
      t_act = 1'b0;
    end else if (rst && !t_act && core_req != '0) begin
      for (int k = 1; k <= NC; k++) begin
        if (core_req[(m_last + k) % NC]) begin
          t_g = (m_last + k) % NC;
          break;
        end
      end
      t_act  = 1'b1;
      t_s    = cyc;
      t_we   = core_we[t_g];
      t_addr = core_addr[t_g*AW +: AW];
      t_wd   = core_wdata[t_g*DW +: DW];
      t_e    = cyc + (t_we ? 2 : 2 + RDL);
      e_addr = t_addr;
      e_wdata = t_wd;
    end
  endtask

  task automatic raise(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i] = 1'b1;
    core_we[i]  = we;
    core_addr[i*AW +: AW]  = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  // Core behaviour: drop req after ack, optionally request/withdraw/scramble.
  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      if (ack_seen[i]) begin
        core_req[i] = 1'b0;
        ack_seen[i] = 1'b0;
      end else if (t_act && t_g == i) begin
        if (rnd_en && $urandom_range(0, 7) == 0) core_req[i] = 1'b0;
        if (rnd_en && $urandom_range(0, 3) == 0) begin
          core_we[i] = ~core_we[i];
          core_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
          core_wdata[i*DW +: DW] = DW'($urandom);
        end
      end else if (!core_req[i] && (hold_mask[i] || (rnd_en && $urandom_range(0, 3) == 0))) begin
        raise(i, hold_mask[i] ? 1'b0 : 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    drive_cores();
  endtask

  task automatic run_until_idle(input int maxc);
    int c;
    c = 0;
    while ((core_req != '0 || t_act) && c < maxc) begin
      step();
      c++;
    end
    chk("drain_timeout", 32'(core_req != '0 || t_act), 32'(0));
  endtask

  initial begin
    int c0;
    rst = 1'b0; ram_clear = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    req3 = '0; we3 = '0; addr3 = '0; wd3 = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = ram_init(i);
    @(posedge clk); #1;
    step(); step();
    chk("rst3_ack",  32'(ack3),   32'(0));
    chk("rst3_busy", 32'(busy3),  32'(0));
    chk("rst3_addr", 32'(maddr3), 32'(0));
    rst = 1'b1; ram_clear = 1'b0;
    step();

    // RD_LAT=3: read from core 1, ack expected in cycle 5
    addr3[1*AW +: AW] = 16'd7; we3[1] = 1'b0; req3[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("d3_rd_ack",  32'(ack3),   (c == 5) ? 32'h2 : 32'h0);
      chk("d3_rd_busy", 32'(busy3),  32'(c >= 1 && c <= 5));
      chk("d3_rd_wren", 32'(mwren3), 32'(0));
      if (c == 5) chk("d3_rd_data", 32'(rdata3), 32'(f3(16'd7)));
      @(posedge clk); #1;
      if (c == 5) req3[1] = 1'b0;
    end
    // RD_LAT=3: write from core 2, ack in cycle 2, read data unchanged
    addr3[2*AW +: AW] = 16'd3; wd3[2*DW +: DW] = 16'hBEEF; we3[2] = 1'b1; req3[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("d3_wr_ack",  32'(ack3),   (c == 2) ? 32'h4 : 32'h0);
      chk("d3_wr_wren", 32'(mwren3), 32'(c == 1));
      chk("d3_wr_busy", 32'(busy3),  32'(c == 1 || c == 2));
      chk("d3_wr_hold", 32'(rdata3), 32'(f3(16'd7)));
      if (c == 1) begin
        chk("d3_wr_addr",  32'(maddr3), 32'h3);
        chk("d3_wr_wdata", 32'(mwd3),   32'hBEEF);
      end
      @(posedge clk); #1;
      if (c == 2) req3[2] = 1'b0;
    end

    // Contention right after reset: order 0,1,2,3
    ack_q.delete();
    for (int i = 0; i < NC; i++) raise(i, 1'b1, AW'(8 + i), DW'(16'h1000 + i));
    run_until_idle(100);
    chk("cont_n", 32'(ack_q.size()), 32'(4));
    for (int k = 0; k < 4 && k < ack_q.size(); k++) chk("cont_order", 32'(ack_q[k]), 32'(k));

    // Single write then read-back of address 5
    c0 = cyc;
    raise(0, 1'b1, 16'h0005, 16'h1234);
    run_until_idle(100);
    chk("wr_lat", 32'(last_ack_cyc - c0), 32'(2));
    c0 = cyc;
    raise(1, 1'b0, 16'h0005, 16'h0000);
    run_until_idle(100);
    chk("rd_lat",  32'(last_ack_cyc - c0), 32'(2 + RDL));
    chk("rd_data", 32'(core_rdata), 32'h1234);

    // Fairness: after core 2, cores 1 and 3 together -> 3 then 1
    raise(2, 1'b1, 16'h000A, 16'h2222);
    run_until_idle(100);
    ack_q.delete();
    raise(1, 1'b0, 16'h0008, 16'h0);
    raise(3, 1'b0, 16'h0009, 16'h0);
    run_until_idle(100);
    chk("fair_n", 32'(ack_q.size()), 32'(2));
    for (int k = 0; k < 2 && k < ack_q.size(); k++) chk("fair_order", 32'(ack_q[k]), (k == 0) ? 32'd3 : 32'd1);

    // Cores 0 and 1 requesting continuously must alternate
    ack_q.delete();
    hold_mask = 4'b0011;
    raise(0, 1'b0, 16'h1, 16'h0);
    raise(1, 1'b0, 16'h2, 16'h0);
    repeat (20) step();
    hold_mask = '0;
    run_until_idle(100);
    chk("alt_min", 32'(ack_q.size() >= 4), 32'(1));
    for (int k = 1; k < ack_q.size(); k++) chk("alt_order", 32'(ack_q[k] == ack_q[k-1]), 32'(0));

    // Withdrawal: core 2 drops req in ISSUE and changes its fields
    c0 = cyc;
    raise(2, 1'b1, 16'h0006, 16'h5555);
    step();
    core_req[2] = 1'b0;
    core_addr[2*AW +: AW] = 16'h0009;
    core_wdata[2*DW +: DW] = 16'hDEAD;
    step();
    run_until_idle(100);
    chk("wd_lat", 32'(last_ack_cyc - c0), 32'(2));
    chk("wd_ram", 32'(ram[6]), 32'h5555);

    // Abort: reset during WAIT of core 3's read; afterwards core 0 priority
    raise(2, 1'b1, 16'h000B, 16'h3333);
    run_until_idle(100);
    ack_q.delete();
    raise(3, 1'b0, 16'h0004, 16'h0);
    raise(1, 1'b0, 16'h0007, 16'h0);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("abort_ack",  32'(core_ack), 32'(0));
    chk("abort_busy", 32'(busy),     32'(0));
    chk("abort_wren", 32'(mem_wren), 32'(0));
    step();
    rst = 1'b1;
    run_until_idle(100);
    chk("abort_n", 32'(ack_q.size()), 32'(2));
    for (int k = 0; k < 2 && k < ack_q.size(); k++) chk("abort_order", 32'(ack_q[k]), (k == 0) ? 32'd1 : 32'd3);

    // Randomised traffic with withdrawals and post-grant field changes
    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
